// File: rtl/sig_sample_buffer.sv
// Trigger-aligned, decimated two-channel capture into double-buffered waveform RAM, plus the 0-999 peak readout.
// Read port: 1-cycle latency, display bank only; banks swap on frame_sync in DONE. Optional forced trigger: SIG_AUTO_TRIGGER_EN.
module sig_sample_buffer #(
    parameter int                      SAMPLE_WIDTH = 12,
    parameter int                      BUF_LEN      = 320,
    parameter int                      DECIM        = 4,
    parameter logic [SAMPLE_WIDTH-1:0] TRIG_LEVEL   = 12'h800,
    parameter logic [11:0]             CH0_BASE     = 12'h559,
    parameter logic [11:0]             CH1_BASE     = 12'h6AD,
    parameter logic [11:0]             VALUE_ADDR   = 12'h6A8,
    parameter int                      AUTO_TIMEOUT = 4096
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    samp_valid,
    input  logic [SAMPLE_WIDTH-1:0] samp_ch0,
    input  logic [SAMPLE_WIDTH-1:0] samp_ch1,
    input  logic                    frame_sync,
    input  logic [11:0]             sig_addr,
    output logic [31:0]             sig_data,
    output logic                    capture_done,
    output logic                    trig_armed
);
    localparam int IW = $clog2(BUF_LEN);
    localparam int AW = $clog2(2 * BUF_LEN);
    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic [1:0] {WAIT_TRIG, CAPTURE, DONE} state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_VAL, SEL_CH0, SEL_CH1} sel_t;

    state_t                  state_q, state_d;
    sel_t                    sel_q, sel_d;
    logic [DW-1:0]           dec_q, dec_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    wr_bank_q, wr_bank_d, disp_bank_q, disp_bank_d;
    logic [SAMPLE_WIDTH-1:0] prev_q, prev_d, peak_q, peak_d;
    logic [9:0]              value_q, value_d, val_rd_q, val_rd_d;
    logic                    capture_done_q, capture_done_d, trig_armed_q, trig_armed_d;
    logic                    keep, trig_hit, to_hit, we;
    logic [AW-1:0]           waddr, raddr0, raddr1, rbase;
    logic [11:0]             off0, off1;
    logic [SAMPLE_WIDTH-1:0] ch0_rd_q, ch1_rd_q;
    logic [SAMPLE_WIDTH-1:0] mem0 [2*BUF_LEN];
    logic [SAMPLE_WIDTH-1:0] mem1 [2*BUF_LEN];
    int                      pk4;

`ifdef SIG_AUTO_TRIGGER_EN
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    logic [TW-1:0] to_q, to_d;
    assign to_hit = (to_q == TW'(AUTO_TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
`endif

    assign keep     = samp_valid && (dec_q == '0);
    assign trig_hit = ((prev_q < TRIG_LEVEL) && (samp_ch0 >= TRIG_LEVEL)) || to_hit;
    assign waddr    = (wr_bank_q ? AW'(BUF_LEN) : '0) + AW'(idx_q);
    assign pk4      = int'(peak_q >> 2);

    always_comb begin
        state_d     = state_q;
        dec_d       = dec_q;
        idx_d       = idx_q;
        wr_bank_d   = wr_bank_q;
        disp_bank_d = disp_bank_q;
        prev_d      = prev_q;
        peak_d      = peak_q;
        value_d     = value_q;
        we          = 1'b0;
`ifdef SIG_AUTO_TRIGGER_EN
        to_d        = to_q;
`endif
        if (samp_valid) begin
            dec_d = (dec_q == DW'(DECIM - 1)) ? '0 : dec_q + 1'b1;
        end
        case (state_q)
            WAIT_TRIG: begin
                if (keep) begin
                    prev_d = samp_ch0;
                    if (trig_hit) begin
                        we      = 1'b1;
                        peak_d  = samp_ch0;
                        idx_d   = IW'(1);
                        state_d = CAPTURE;
`ifdef SIG_AUTO_TRIGGER_EN
                        to_d    = '0;
                    end else begin
                        to_d    = to_q + 1'b1;
`endif
                    end
                end
            end
            CAPTURE: begin
                if (keep) begin
                    we     = 1'b1;
                    peak_d = (samp_ch0 > peak_q) ? samp_ch0 : peak_q;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == IW'(BUF_LEN - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Swap happens only here so the display never sees a partial capture.
                if (frame_sync) begin
                    wr_bank_d   = disp_bank_q;
                    disp_bank_d = wr_bank_q;
                    value_d     = (pk4 > 999) ? 10'd999 : 10'(pk4);
                    idx_d       = '0;
                    prev_d      = '0;
                    state_d     = WAIT_TRIG;
`ifdef SIG_AUTO_TRIGGER_EN
                    to_d        = '0;
`endif
                end
            end
            default: state_d = WAIT_TRIG;
        endcase
        capture_done_d = (state_d == DONE);
        trig_armed_d   = (state_d == WAIT_TRIG);
    end

    // Read decode: VALUE_ADDR wins over CH0, CH0 over CH1.
    always_comb begin
        off0     = sig_addr - CH0_BASE;
        off1     = sig_addr - CH1_BASE;
        rbase    = disp_bank_q ? AW'(BUF_LEN) : '0;
        raddr0   = rbase + AW'(off0[IW-1:0]);
        raddr1   = rbase + AW'(off1[IW-1:0]);
        val_rd_d = value_q;
        sel_d    = SEL_NONE;
        if (sig_addr == VALUE_ADDR) begin
            sel_d = SEL_VAL;
        end else if (int'(sig_addr) >= int'(CH0_BASE) && int'(sig_addr) < int'(CH0_BASE) + BUF_LEN) begin
            sel_d = SEL_CH0;
        end else if (int'(sig_addr) >= int'(CH1_BASE) && int'(sig_addr) < int'(CH1_BASE) + BUF_LEN) begin
            sel_d = SEL_CH1;
        end
    end

    always_comb begin
        sig_data = '0;
        case (sel_q)
            SEL_VAL: sig_data = {22'b0, val_rd_q};
            SEL_CH0: sig_data = {{(32-SAMPLE_WIDTH){1'b0}}, ch0_rd_q};
            SEL_CH1: sig_data = {{(32-SAMPLE_WIDTH){1'b0}}, ch1_rd_q};
            default: sig_data = '0;
        endcase
    end

    assign capture_done = capture_done_q;
    assign trig_armed   = trig_armed_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= WAIT_TRIG;
            sel_q          <= SEL_NONE;
            dec_q          <= '0;
            idx_q          <= '0;
            wr_bank_q      <= 1'b0;
            disp_bank_q    <= 1'b1;
            prev_q         <= '0;
            peak_q         <= '0;
            value_q        <= '0;
            val_rd_q       <= '0;
            capture_done_q <= 1'b0;
            trig_armed_q   <= 1'b1;
`ifdef SIG_AUTO_TRIGGER_EN
            to_q           <= '0;
`endif
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            dec_q          <= dec_d;
            idx_q          <= idx_d;
            wr_bank_q      <= wr_bank_d;
            disp_bank_q    <= disp_bank_d;
            prev_q         <= prev_d;
            peak_q         <= peak_d;
            value_q        <= value_d;
            val_rd_q       <= val_rd_d;
            capture_done_q <= capture_done_d;
            trig_armed_q   <= trig_armed_d;
`ifdef SIG_AUTO_TRIGGER_EN
            to_q           <= to_d;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset && we) begin
            mem0[waddr] <= samp_ch0;
            mem1[waddr] <= samp_ch1;
        end
        ch0_rd_q <= mem0[raddr0];
        ch1_rd_q <= mem1[raddr1];
    end
endmodule

// File: doc/sig_sample_buffer.md
Name: sig_sample_buffer

Overview:
- Upstream feeder for the VGA display stage; captures the two-channel sample stream into double-buffered waveform memory.
- Computes the 0-999 readout value.
- Serves the display's sig_addr/sig_data read port with fixed 1-cycle latency.
- Capture is trigger-aligned; banks swap only on frame_sync so a frame never mixes two captures.

Parameters:
- SAMPLE_WIDTH, 12, bits per channel sample.
- BUF_LEN, 320, samples stored per channel per capture.
- DECIM, 4, keep 1 of every DECIM valid samples (DECIM>=1).
- TRIG_LEVEL, 12'h800, ch0 rising-edge trigger threshold.
- CH0_BASE, 12'h559, first read address of the ch0 waveform.
- CH1_BASE, 12'h6AD, first read address of the ch1 waveform.
- VALUE_ADDR, 12'h6A8, read address of the readout value.
- AUTO_TIMEOUT, 4096, decimated samples before a forced trigger (optional feature only).

Ports:
- clock  in  1  system clock (100 MHz domain, same as display RAMs)
- reset  in  1  synchronous, active-low reset
- samp_valid  in  1  one-cycle strobe; samp_ch0/samp_ch1 valid
- samp_ch0  in  SAMPLE_WIDTH  channel 0 sample
- samp_ch1  in  SAMPLE_WIDTH  channel 1 sample
- frame_sync  in  1  one-cycle pulse at display frame end
- sig_addr  in  12  display read address
- sig_data  out  32  read data, registered
- capture_done  out  1  high while a finished capture awaits swap
- trig_armed  out  1  high in WAIT_TRIG

Behaviour:
- Reset (reset==0 at posedge clock) has priority over all other inputs, including mid-capture:
  - state=WAIT_TRIG; decimation counter=0; write index=0; wr_bank=0; disp_bank=1; prev_ch0=0; peak=0; value=0.
  - sig_data=0; capture_done=0; trig_armed=1 (after the reset edge).
  - Memory contents are not cleared.
- Decimation:
  - Counter advances on each samp_valid and wraps DECIM-1 -> 0.
  - A sample is "kept" when samp_valid and counter==0.
  - Samples arriving in DONE still advance the counter but are discarded.
- States:
  - WAIT_TRIG: on each kept sample, prev_ch0 <= ch0.
    - Trigger when prev_ch0 < TRIG_LEVEL and ch0 >= TRIG_LEVEL.
    - The trigger sample is written at index 0 of wr_bank; peak <= ch0; go to CAPTURE with index=1.
  - CAPTURE: each kept sample is written at index, both channels; peak <= max(peak, ch0); index++.
    - The sample written at index BUF_LEN-1 moves to DONE next edge.
    - No re-trigger inside CAPTURE.
  - DONE: capture_done=1.
    - On frame_sync: swap wr_bank/disp_bank; value <= min(peak>>2, 999) (10-bit unsigned, saturating); index=0; prev_ch0=0; go to WAIT_TRIG.
    - A frame_sync in any other state is ignored, including the cycle of the final CAPTURE write.
- Read port (1-cycle latency, reads disp_bank only, never the bank being written):
  - sig_addr in [CH0_BASE, CH0_BASE+BUF_LEN-1] -> sig_data = {20'b0, ch0[sig_addr-CH0_BASE]}.
  - Same rule for CH1_BASE with ch1.
  - VALUE_ADDR -> {22'b0, value}.
  - Any other address -> 0.
  - If regions overlap, priority is VALUE_ADDR, then CH0, then CH1.
- Storage: two banks × two channels × BUF_LEN × SAMPLE_WIDTH, synchronous-read block RAM inferable; one write and one read per cycle.
- Swap is atomic: the read on the frame_sync cycle returns the old bank; from the next cycle reads return the new bank.

Optional Feature:
- Macro: SIG_AUTO_TRIGGER_EN.
- Defined:
  - A timeout counter counts kept samples in WAIT_TRIG.
  - When it reaches AUTO_TIMEOUT-1 without a trigger, the next kept sample triggers unconditionally.
  - The counter clears on entering WAIT_TRIG and on reset.
- Undefined: no counter; WAIT_TRIG holds indefinitely; no added logic.

Test Plan:
- Reset mid-CAPTURE: drive reset=0 at index 100 -> next cycle trig_armed=1, capture_done=0, sig_data=0; reads at VALUE_ADDR return 0.
- Trigger with DECIM=4, samples every cycle:
  - ch0 ramp 0x000..0xFFF step 0x10 -> trigger on first kept sample >= 0x800 after a kept sample < 0x800.
  - After 320 kept samples capture_done=1.
- Swap: after DONE, pulse frame_sync, then read CH0_BASE -> trigger sample value; read CH0_BASE+319 -> last kept sample; VALUE_ADDR -> min(peak>>2, 999) = 999 for peak 0xFFF.
- Tear-free: during a second CAPTURE, reads of CH1_BASE+5 stay constant across cycles until the next frame_sync.
- Boundary addresses: CH0_BASE-1 -> 0, CH0_BASE+320 -> 0; frame_sync on the final-write cycle -> no swap, capture_done rises next cycle.
- SIG_AUTO_TRIGGER_EN with constant ch0=0x100, AUTO_TIMEOUT=16 -> capture starts on kept sample 16; without the macro capture_done stays 0 indefinitely.
